// File: rtl/decomp_pkg.sv
// Codeword definitions shared by the compression and decompression stages,
// so both sides agree on code values and on which codes touch the dictionary.
package decomp_pkg;

   localparam int WORD       = 32;
   localparam int DICT_ENTRY = 16;
   localparam int LOC_W      = $clog2(DICT_ENTRY);

   typedef enum logic [2:0] {
      CODE_ZZZZ = 3'b000,
      CODE_ZZZX = 3'b001,
      CODE_MMMM = 3'b010,
      CODE_MMMX = 3'b011,
      CODE_MMXX = 3'b100,
      CODE_XXXX = 3'b101,
      CODE_ILL6 = 3'b110,
      CODE_ILL7 = 3'b111
   } code_e;

   function automatic logic code_reads_dict(input logic [2:0] code);
      return (code == CODE_MMMM) || (code == CODE_MMMX) || (code == CODE_MMXX);
   endfunction

   // Write-control rule must match the compressor exactly or the mirrors drift apart.
   function automatic logic code_writes_dict(input logic [2:0] code);
      return (code == CODE_MMMX) || (code == CODE_MMXX) || (code == CODE_XXXX);
   endfunction

   function automatic logic code_is_illegal(input logic [2:0] code);
      return (code == CODE_ILL6) || (code == CODE_ILL7);
   endfunction

endpackage

// File: rtl/decompress_stage_dict.sv
// Mirror FIFO dictionary: two ordered writes and two reads per beat, with
// occupancy tracking and a same-beat bypass from the first write to the second read.
module decomp_dict
   import decomp_pkg::*;
#(
   parameter  int WORD       = 32,
   parameter  int DICT_ENTRY = 16,
   localparam int LOC_W      = $clog2(DICT_ENTRY),
   localparam int CNT_W      = $clog2(DICT_ENTRY + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_wr1,
   input  logic             i_wr2,
   input  logic [WORD-1:0]  i_wdata1,
   input  logic [WORD-1:0]  i_wdata2,
   input  logic [LOC_W-1:0] i_rloc1,
   input  logic [LOC_W-1:0] i_rloc2,
   output logic [WORD-1:0]  o_rdata1,
   output logic [WORD-1:0]  o_rdata2,
   output logic             o_rd1_ok,
   output logic             o_rd2_ok,
   output logic             o_full
);

   logic [WORD-1:0]  r_mem [DICT_ENTRY];
   logic [LOC_W-1:0] r_wp;
   logic [CNT_W-1:0] r_count;

   logic [LOC_W-1:0] w_wp2;
   logic [LOC_W-1:0] w_wp_next;
   logic [CNT_W-1:0] w_cnt1;
   logic [CNT_W-1:0] w_cnt2;
   logic             w_full1;

   assign o_full    = (r_count == CNT_W'(DICT_ENTRY));
   assign w_wp2     = i_wr1 ? r_wp + LOC_W'(1) : r_wp;
   assign w_wp_next = i_wr2 ? w_wp2 + LOC_W'(1) : w_wp2;

   // Word 2 is judged against the occupancy after word 1 has written.
   assign w_cnt1  = (i_wr1 && !o_full) ? r_count + CNT_W'(1) : r_count;
   assign w_full1 = (w_cnt1 == CNT_W'(DICT_ENTRY));
   assign w_cnt2  = (i_wr2 && !w_full1) ? w_cnt1 + CNT_W'(1) : w_cnt1;

   assign o_rdata1 = r_mem[i_rloc1];
   assign o_rdata2 = (i_wr1 && (i_rloc2 == r_wp)) ? i_wdata1 : r_mem[i_rloc2];

   assign o_rd1_ok = o_full  || (CNT_W'(i_rloc1) < r_count);
   assign o_rd2_ok = w_full1 || (CNT_W'(i_rloc2) < w_cnt1);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DICT_ENTRY; i++) r_mem[i] <= '0;
         r_wp    <= '0;
         r_count <= '0;
      end else if (i_en) begin
         if (i_wr1) r_mem[r_wp]  <= i_wdata1;
         if (i_wr2) r_mem[w_wp2] <= i_wdata2;
         r_wp    <= w_wp_next;
         r_count <= w_cnt2;
      end
   end

endmodule

// File: rtl/decompress_stage.sv
// Decompression stage: rebuilds a word pair from two codewords against a
// mirror dictionary, with a single registered output beat and ready/valid flow.
module decompress_stage
   import decomp_pkg::*;
#(
   parameter  int WIDTH      = 64,
   parameter  int WORD       = 32,
   parameter  int DICT_ENTRY = 16,
   localparam int LOC_W      = $clog2(DICT_ENTRY)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_code1,
   input  logic [2:0]       i_code2,
   input  logic [LOC_W-1:0] i_location1,
   input  logic [LOC_W-1:0] i_location2,
   input  logic [WORD-1:0]  i_payload1,
   input  logic [WORD-1:0]  i_payload2,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_word,
   output logic             o_dict_full,
   output logic             o_err
);

   function automatic logic [WORD-1:0] decode_word(input logic [2:0]      code,
                                                   input logic [WORD-1:0] dval,
                                                   input logic [WORD-1:0] pay);
      case (code)
         CODE_ZZZZ: return '0;
         CODE_ZZZX: return {{(WORD-8){1'b0}}, pay[7:0]};
         CODE_MMMM: return dval;
         CODE_MMMX: return {dval[WORD-1:8], pay[7:0]};
         CODE_MMXX: return {dval[WORD-1:16], pay[15:0]};
         CODE_XXXX: return pay;
         default:   return '0;
      endcase
   endfunction

   logic             w_accept;
   logic             w_wr1;
   logic             w_wr2;
   logic [WORD-1:0]  w_dict1;
   logic [WORD-1:0]  w_dict2;
   logic             w_rd1_ok;
   logic             w_rd2_ok;
   logic [WORD-1:0]  w_word1;
   logic [WORD-1:0]  w_word2;
   logic             w_err;

   logic             r_vld_p1;
   logic [WIDTH-1:0] r_word_p1;
   logic             r_err;

   assign o_ready  = !r_vld_p1 || i_ready;
   assign w_accept = i_valid && o_ready;
   assign w_wr1    = code_writes_dict(i_code1);
   assign w_wr2    = code_writes_dict(i_code2);

   decomp_dict #(
      .WORD       (WORD),
      .DICT_ENTRY (DICT_ENTRY)
   ) u_dict (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_en     (w_accept),
      .i_wr1    (w_wr1),
      .i_wr2    (w_wr2),
      .i_wdata1 (w_word1),
      .i_wdata2 (w_word2),
      .i_rloc1  (i_location1),
      .i_rloc2  (i_location2),
      .o_rdata1 (w_dict1),
      .o_rdata2 (w_dict2),
      .o_rd1_ok (w_rd1_ok),
      .o_rd2_ok (w_rd2_ok),
      .o_full   (o_dict_full)
   );

   assign w_word1 = decode_word(i_code1, w_dict1, i_payload1);
   assign w_word2 = decode_word(i_code2, w_dict2, i_payload2);

   // Stale-slot reads still decode with the slot contents; they only flag the error.
   assign w_err = code_is_illegal(i_code1) || code_is_illegal(i_code2) ||
                  (code_reads_dict(i_code1) && !w_rd1_ok) ||
                  (code_reads_dict(i_code2) && !w_rd2_ok);

   // Stage p0 -> p1: decoded pair registered on accept
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_vld_p1  <= 1'b0;
         r_word_p1 <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_word_p1 <= {w_word2, w_word1};
         end else if (i_ready) begin
            r_vld_p1  <= 1'b0;
         end
         if (w_accept && w_err) r_err <= 1'b1;
      end
   end

   assign o_valid = r_vld_p1;
   assign o_word  = r_word_p1;
   assign o_err   = r_err;

endmodule

// File: doc/decompress_stage.md
Name: decompress_stage

Overview:
- Decompression counterpart of the compression matching stage. Takes two parsed codewords per beat: code, dictionary location and literal payload.
- Rebuilds the original 64-bit word pair: first word in [31:0], second word in [63:32].
- Holds a mirror 16x32 FIFO dictionary. It is updated with exactly the same write rule the compressor uses, so both dictionaries stay in lockstep.
- Sits between the codeword unpacker (upstream) and the output word buffer (downstream).

Parameters:
- WIDTH, 64, output word-pair width (2 x WORD).
- WORD, 32, uncompressed word width.
- DICT_ENTRY, 16, number of dictionary entries; location width is $clog2(DICT_ENTRY).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  stage can accept a beat.
- i_code1  input  3  code for first word.
- i_code2  input  3  code for second word.
- i_location1  input  4  dictionary slot for first word.
- i_location2  input  4  dictionary slot for second word.
- i_payload1  input  32  literal bits for first word, LSB-aligned.
- i_payload2  input  32  literal bits for second word, LSB-aligned.
- o_valid  output  1  o_word holds a decoded pair.
- i_ready  input  1  downstream accepts o_word.
- o_word  output  64  decoded pair {second, first}.
- o_dict_full  output  1  all DICT_ENTRY slots written since reset.
- o_err  output  1  sticky decode error.

Behaviour:

Codes:
- 000 ZZZZ -> 0.
- 001 ZZZX -> {24'h0, payload[7:0]}.
- 010 MMMM -> dict[loc].
- 011 MMMX -> {dict[loc][31:8], payload[7:0]}.
- 100 MMXX -> {dict[loc][31:16], payload[15:0]}.
- 101 XXXX -> payload.
- 110/111 illegal -> word 0, set o_err, no dictionary write.

Handshake:
- o_ready = !o_valid || i_ready (combinational). A beat is accepted when i_valid && o_ready.
- Latency 1: the decoded pair is registered into o_word and o_valid=1 on the accept edge.
- o_valid clears on i_ready when no new beat is accepted.
- o_word holds stable while o_valid && !i_ready.
- Full throughput: one pair per cycle when i_ready is held high.

Dictionary:
- Written on accept only, for codes MMMX, MMXX and XXXX (matching the compressor's write-control rule). The decoded word is written, not the payload.
- Write pointer wp starts at 0, increments mod DICT_ENTRY per write, and wraps over the oldest entry.
- The first word writes before the second: two writes in one beat use slots wp and wp+1 (mod 16), and wp advances by 2.
- In-beat bypass: if word 1 writes slot S and i_location2==S with a dict-reading code2, word 2 uses the newly decoded word 1, not the stale content.
- Wrap case: a second word reading a slot overwritten in the same beat sees the new value.

Occupancy:
- A count saturates at DICT_ENTRY. o_dict_full = (count==DICT_ENTRY) and is sticky until reset.
- Reading a location >= count while not full sets o_err. The stale slot value (0 after reset) is still used.

Reset:
- Asynchronous. o_valid=0, o_word=0, o_err=0, o_dict_full=0, wp=0, count=0, all entries 0.
- Reset mid-stream drops the registered output beat. o_ready reads 1 after reset.

Decomposition:
- Package decomp_pkg:
  - Code enum (ZZZZ..XXXX, illegal) and per-code dict-read/dict-write flags.
  - Constants WORD=32, DICT_ENTRY=16, LOC_W=4.
  - Shared with the compression side so both agree on code values.
- Sub-module decomp_dict: 2-write/2-read mirror dictionary with pointer, count, full and bypass.
- Top: decode muxes, error logic, output register and handshake.

Test Plan:
- Reset, then beat {code1=XXXX payload1=32'hDEADBEEF, code2=ZZZZ} -> o_word=64'h00000000_DEADBEEF one cycle later; slot0=DEADBEEF; count=1.
- Next beat {code1=MMMM loc1=0, code2=MMXX loc2=0 payload2=16'h1234} -> o_word=64'hDEAD1234_DEADBEEF; slot1=DEAD1234.
- Same-beat bypass: {code1=XXXX payload1=32'hCAFEF00D, code2=MMMX loc2=wp payload2=8'h77} -> second word = CAFEF077; wp advances by 2.
- 16 XXXX words written -> o_dict_full=1 after the 16th. A 17th XXXX overwrites slot0; MMMM loc=0 then returns the new value.
- i_ready=0 for 3 cycles with o_valid=1 -> o_ready=0, o_word stable. i_ready=1 -> next beat accepted the same cycle; no loss or duplicate.
- Illegal code 110 -> word 0, o_err=1 and stays 1. MMMM to unwritten loc=5 at count=2 -> o_err=1. Async reset mid-stream clears all outputs immediately.
